// File: rtl/tpu_serial_loader.sv
// rtl/tpu_serial_loader.sv - deserializes two 1-bit operand streams into N x N matrices
// and hands them to the systolic core through a valid/ready handshake.
module tpu_serial_loader #(
  parameter int D_W = 8,
  parameter int N   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          data_in_x,
  input  logic                          data_in_y,
  input  logic                          load_en,
  input  logic                          init,
  output logic [N*N*D_W-1:0]            mat_x_flat,
  output logic [N*N*D_W-1:0]            mat_y_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(N*N+1)-1:0]      elem_cnt,
  output logic                          busy
);

  localparam int NE = N * N;
  localparam int MW = NE * D_W;
  localparam int EW = $clog2(NE + 1);
  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(D_W - 1);
  localparam logic [EW-1:0] LAST_ELEM = EW'(NE - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [EW-1:0]   elem_cnt_d;
  logic [D_W-1:0]  sr_x_q, sr_x_d, sr_y_q, sr_y_d;
  logic [D_W-1:0]  word_x, word_y;
  logic [MW-1:0]   mat_x_d, mat_y_d;
  logic            out_valid_d;

  // Word as it stands once the current bit is shifted in.
  assign word_x = {sr_x_q[D_W-2:0], data_in_x};
  assign word_y = {sr_y_q[D_W-2:0], data_in_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      elem_cnt   <= '0;
      sr_x_q     <= '0;
      sr_y_q     <= '0;
      mat_x_flat <= '0;
      mat_y_flat <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      elem_cnt   <= elem_cnt_d;
      sr_x_q     <= sr_x_d;
      sr_y_q     <= sr_y_d;
      mat_x_flat <= mat_x_d;
      mat_y_flat <= mat_y_d;
      out_valid  <= out_valid_d;
      busy       <= (state_d == SHIFT);
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    elem_cnt_d  = elem_cnt;
    sr_x_d      = sr_x_q;
    sr_y_d      = sr_y_q;
    mat_x_d     = mat_x_flat;
    mat_y_d     = mat_y_flat;
    out_valid_d = out_valid;

    if (init) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      elem_cnt_d  = '0;
      sr_x_d      = '0;
      sr_y_d      = '0;
      mat_x_d     = '0;
      mat_y_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_en) begin
            sr_x_d    = {{(D_W-1){1'b0}}, data_in_x};
            sr_y_d    = {{(D_W-1){1'b0}}, data_in_y};
            bit_cnt_d = BW'(1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (load_en) begin
            sr_x_d = word_x;
            sr_y_d = word_y;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = '0;
              elem_cnt_d = elem_cnt + EW'(1);
              for (int e = 0; e < NE; e++) begin
                if (EW'(e) == elem_cnt) begin
                  mat_x_d[e*D_W +: D_W] = word_x;
                  mat_y_d[e*D_W +: D_W] = word_y;
                end
              end
              if (elem_cnt == LAST_ELEM) begin
                state_d     = FULL;
                out_valid_d = 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        FULL: begin
          // Serial input is dropped here; matrices stay frozen until accepted.
          if (out_valid && out_ready) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            elem_cnt_d  = '0;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_serial_loader.sv
// tb/tb_tpu_serial_loader.sv - randomized self-checking bench for tpu_serial_loader
// against a bit-count based reference model.
module tb_tpu_serial_loader;

  localparam int D_W = 8;
  localparam int N   = 2;
  localparam int NE  = N * N;
  localparam int MW  = NE * D_W;
  localparam int EW  = $clog2(NE + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          data_in_x, data_in_y, load_en, init, out_ready;
  logic [MW-1:0] mat_x_flat, mat_y_flat;
  logic          out_valid, busy;
  logic [EW-1:0] elem_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: count of qualified bits since the last clear.
  int             nbits;
  bit             full;
  logic [D_W-1:0] wx, wy;
  logic [D_W-1:0] ex [NE];
  logic [D_W-1:0] ey [NE];

  tpu_serial_loader #(.D_W(D_W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_x(data_in_x), .data_in_y(data_in_y),
    .load_en(load_en), .init(init), .mat_x_flat(mat_x_flat), .mat_y_flat(mat_y_flat),
    .out_valid(out_valid), .out_ready(out_ready), .elem_cnt(elem_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear(input bit clear_mats);
    nbits = 0;
    full  = 0;
    wx    = '0;
    wy    = '0;
    if (clear_mats) for (int e = 0; e < NE; e++) begin ex[e] = '0; ey[e] = '0; end
  endtask

  task automatic model_step();
    if (init) model_clear(1);
    else if (full) begin
      if (out_ready) model_clear(0);
    end else if (load_en) begin
      wx = {wx[D_W-2:0], data_in_x};
      wy = {wy[D_W-2:0], data_in_y};
      nbits++;
      if (nbits % D_W == 0) begin
        ex[nbits/D_W - 1] = wx;
        ey[nbits/D_W - 1] = wy;
        if (nbits == NE * D_W) full = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [MW-1:0] fx, fy;
    for (int e = 0; e < NE; e++) begin
      fx[e*D_W +: D_W] = ex[e];
      fy[e*D_W +: D_W] = ey[e];
    end
    check("out_valid", 64'(out_valid), 64'(full));
    check("busy", 64'(busy), 64'(!full && nbits > 0));
    check("elem_cnt", 64'(elem_cnt), full ? 64'(NE) : 64'(nbits / D_W));
    check("mat_x", 64'(mat_x_flat), 64'(fx));
    check("mat_y", 64'(mat_y_flat), 64'(fy));
  endtask

  // Drive one cycle from the falling edge, then check after the next falling edge.
  task automatic cycle(input logic x, input logic y, input logic le, input logic ini, input logic rdy);
    data_in_x = x; data_in_y = y; load_en = le; init = ini; out_ready = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic load_word(input logic [D_W-1:0] x, input logic [D_W-1:0] y);
    for (int b = D_W - 1; b >= 0; b--) cycle(x[b], y[b], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load_rand_matrix();
    for (int e = 0; e < NE; e++) load_word(D_W'($urandom), D_W'($urandom));
  endtask

  initial begin
    logic [D_W-1:0] a5, c3;
    rst_n = 1'b0; data_in_x = 0; data_in_y = 0; load_en = 0; init = 0; out_ready = 0;
    model_clear(1);
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // Known matrices, MSB first.
    load_word(8'h01, 8'h10); load_word(8'h02, 8'h20);
    load_word(8'h03, 8'h30); load_word(8'h04, 8'h40);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_matx", 64'(mat_x_flat), 64'h04030201);
    check("t1_maty", 64'(mat_y_flat), 64'h40302010);
    check("t1_elem", 64'(elem_cnt), 64'd4);

    // Held in FULL under back-pressure, then accepted.
    repeat (10) cycle(1'($urandom), 1'($urandom), 1'b1, 1'b0, 1'b0);
    check("t2_matx_hold", 64'(mat_x_flat), 64'h04030201);
    check("t2_valid_hold", 64'(out_valid), 64'd1);
    cycle(0, 0, 0, 0, 1);
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    check("t2_elem_clr", 64'(elem_cnt), 64'd0);

    // Paused element.
    a5 = 8'hA5; c3 = 8'h3C;
    for (int b = 7; b >= 5; b--) cycle(a5[b], c3[b], 1, 0, 0);
    repeat (5) cycle(1'($urandom), 1'($urandom), 0, 0, 0);
    check("t3_busy_pause", 64'(busy), 64'd1);
    for (int b = 4; b >= 0; b--) cycle(a5[b], c3[b], 1, 0, 0);
    check("t3_elem0", 64'(mat_x_flat[7:0]), 64'hA5);
    check("t3_elem_cnt", 64'(elem_cnt), 64'd1);

    // init with element 1 half loaded.
    repeat (4) cycle(1'($urandom), 1'($urandom), 1, 0, 0);
    cycle(1, 1, 1, 1, 0);
    check("t4_elem", 64'(elem_cnt), 64'd0);
    check("t4_matx", 64'(mat_x_flat), 64'd0);
    check("t4_busy", 64'(busy), 64'd0);
    load_rand_matrix();
    check("t4_full", 64'(out_valid), 64'd1);
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset between edges mid-load.
    repeat (10) cycle(1'($urandom), 1'($urandom), 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_clear(1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_elem", 64'(elem_cnt), 64'd0);
    check("t5_matx", 64'(mat_x_flat), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_rand_matrix();
    check("t5_reload", 64'(out_valid), 64'd1);

    // Handshake with a simultaneous qualified bit: bit dropped.
    cycle(1, 1, 1, 0, 1);
    check("t6_valid", 64'(out_valid), 64'd0);
    load_word(8'h5A, 8'hC3);
    check("t6_elem0_x", 64'(mat_x_flat[7:0]), 64'h5A);
    check("t6_elem0_y", 64'(mat_y_flat[7:0]), 64'hC3);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom), 1'($urandom), ($urandom % 10) < 7,
            ($urandom % 100) < 2, ($urandom % 10) < 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
